f1_start_seq: RTL and testbench
===============================

Name: f1_start_seq

Overview:
- Parametrised F1 start-light sequencer with built-in reaction timer. It is the successor to the fixed 10-LED FSM, delay and LFSR chain.
- Features:
  - configurable light count, step period and random hold window;
  - measures driver reaction in ms from lights-out;
  - detects false starts;
  - tracks the best time.
- Sits between the clktick ms divider and the bin2bcd/hexto7seg display path. It is clocked at system clock and gated by the tick_ms enable.

Parameters:
- N_LIGHTS, 10: number of start lights (1..16).
- STEP_MS, 500: ms ticks between successive lights turning on.
- MIN_HOLD_MS, 200: minimum hold time with all lights on.
- HOLD_BITS, 6: random hold range is 0..2^HOLD_BITS-1 steps.
- HOLD_STEP_MS, 50: ms per random hold step.
- TIME_W, 14: width of the reaction and best-time counters, in ms.
- LFSR_SEED, 7'h01: non-zero seed of the internal 7-bit LFSR.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- tick_ms  in  1  one-cycle enable pulse every 1 ms
- trigger  in  1  start request, level, already synchronised
- react  in  1  driver response, level, already synchronised
- lights  out  N_LIGHTS  light drive; bit 0 is the first light on
- busy  out  1  high in SEQ, HOLD and TIMING
- react_time  out  TIME_W  last measured reaction in ms
- time_valid  out  1  one-cycle pulse when react_time updates
- timeout  out  1  sticky; reaction counter saturated
- false_start  out  1  sticky; react seen before lights-out
- best_time  out  TIME_W  minimum valid react_time since reset

Behaviour:
- Reset values:
  - lights=0, busy=0, react_time=0, time_valid=0, timeout=0, false_start=0.
  - best_time = all ones; state=IDLE; LFSR=LFSR_SEED.
  - rst has priority over every other input in any state, including mid-sequence.
- Edges: trigger and react are rising-edge detected internally, with one registered copy each. The edge history register resets to 1, so a level held through reset does not produce an edge.
- LFSR: 7-bit maximal-length, x^7+x^6+1. It advances every clk cycle regardless of state. It never reaches 0.
- Counters: every ms counter changes only on cycles with tick_ms=1.
- States are IDLE, SEQ, HOLD, TIMING, DONE and FAULT.
- IDLE:
  - lights=0.
  - A trigger edge moves to SEQ. On that next clock lights=1 (bit 0), step_cnt=0, and false_start and timeout clear.
- SEQ:
  - step_cnt counts ticks.
  - When step_cnt reaches STEP_MS-1 on a tick, it resets to 0 and the next light bit turns on; lights fill as a thermometer code.
  - On the tick that would light bit N_LIGHTS-1, that bit turns on and the state moves to HOLD.
  - On the same clock, hold_cnt loads MIN_HOLD_MS + (LFSR[HOLD_BITS-1:0] × HOLD_STEP_MS), using the LFSR value sampled in that cycle.
- HOLD:
  - All lights stay on and hold_cnt decrements each tick.
  - On the tick where hold_cnt==0: lights go to 0, rt_cnt=0, and the state moves to TIMING.
  - lights=0 is visible the clock after that tick.
- TIMING:
  - rt_cnt increments each tick and saturates at 2^TIME_W-1.
  - On saturation: timeout=1, react_time = all ones, time_valid pulses, go to DONE. best_time is not updated.
  - On a react edge: react_time=rt_cnt, time_valid pulses for one cycle, go to DONE.
  - best_time = min(best_time, rt_cnt).
  - A react edge on the same cycle as the tick uses the pre-increment rt_cnt.
- False start:
  - A react edge in SEQ or HOLD sets false_start=1 and lights=0, and moves to FAULT.
  - react_time, time_valid and best_time are unchanged.
- DONE and FAULT:
  - Hold all outputs.
  - A trigger edge restarts exactly as from IDLE.
- Trigger edges in SEQ, HOLD or TIMING are ignored.
- Simultaneous edges:
  - If a react edge and the hold expiry fall on the same cycle, it is a false start.
  - If trigger and react edges arrive together in DONE/FAULT, trigger wins.
- busy is a registered decode of the state.

Decomposition:
- Package f1_pkg:
  - state enum f1_state_t {IDLE, SEQ, HOLD, TIMING, DONE, FAULT};
  - localparam LFSR_W=7;
  - the tap-mask constant.
- Sub-module lfsr7, a parametrised-seed Fibonacci LFSR with clk, rst and a q output. It replaces the commented-out lfsr instance.
- All remaining logic sits in one always_ff plus next-state always_comb.

Test Plan:
The bench uses N_LIGHTS=5, STEP_MS=2, MIN_HOLD_MS=3, HOLD_STEP_MS=1, HOLD_BITS=2, TIME_W=6, and tick_ms every 4 clk.
- Normal run:
  - Stimulus: trigger pulse, then force LFSR[1:0]=2 at HOLD entry, then react 7 ticks after lights-out.
  - Response: lights go 00001→00011→…→11111, 2 ticks apart; all lights on lasts 5 ticks; then lights=0.
  - Result: react_time=7, one time_valid pulse, best_time=7.
- Best-time tracking: a second run with react after 4 ticks gives best_time=4. A third with react after 9 ticks gives react_time=9 and best_time stays 4.
- False start: react edge while lights=00111 → false_start=1, lights=0, state FAULT, react_time/best_time unchanged. A later trigger clears false_start and lights=00001.
- Timeout: no react after lights-out → after 63 ticks timeout=1, react_time=63, one time_valid pulse, best_time unchanged.
- Reset mid-sequence: rst during HOLD → next cycle all outputs at reset values. A trigger held high through reset does not start a sequence until it is released and re-asserted.
- Boundary: react edge on the exact hold-expiry tick → false_start=1. A trigger during TIMING is ignored (busy stays 1).

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

  typedef enum logic [2:0] {IDLE, SEQ, HOLD, TIMING, DONE, FAULT} f1_state_t;

  localparam int LFSR_W = 7;
  // Taps for x^7 + x^6 + 1 (bits 6 and 5 of a left-shifting register)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr7.sv
// Free-running 7-bit Fibonacci LFSR; a non-zero seed keeps it off the all-zero lock-up state.
module lfsr7
  import f1_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 7'h01
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb q_d = lfsr_next(q_q);

  always_ff @(posedge clk) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: thermometer light fill, random hold, then reaction
// timing in ms with false-start, timeout and best-time tracking.
module f1_start_seq
  import f1_pkg::*;
#(
  parameter int               N_LIGHTS     = 10,
  parameter int               STEP_MS      = 500,
  parameter int               MIN_HOLD_MS  = 200,
  parameter int               HOLD_BITS    = 6,
  parameter int               HOLD_STEP_MS = 50,
  parameter int               TIME_W       = 14,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 7'h01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_ms,
  input  logic                trigger,
  input  logic                react,
  output logic [N_LIGHTS-1:0] lights,
  output logic                busy,
  output logic [TIME_W-1:0]   react_time,
  output logic                time_valid,
  output logic                timeout,
  output logic                false_start,
  output logic [TIME_W-1:0]   best_time
);

  localparam int STEP_W   = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam int HOLD_MAX = MIN_HOLD_MS + ((1 << HOLD_BITS) - 1) * HOLD_STEP_MS;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_MS - 1);
  localparam logic [LFSR_W-1:0]   HOLD_MASK = LFSR_W'((1 << HOLD_BITS) - 1);
  localparam logic [TIME_W-1:0]   RT_MAX    = '1;
  localparam logic [N_LIGHTS-1:0] LIGHT0    = N_LIGHTS'(1);

  f1_state_t             state_q, state_d;
  logic [N_LIGHTS-1:0]   lights_q, lights_d, lights_fill;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [HOLD_W-1:0]     hold_q, hold_d, hold_load;
  logic [TIME_W-1:0]     rt_q, rt_d, rtime_q, rtime_d, best_q, best_d;
  logic                  busy_q, busy_d, tvalid_q, tvalid_d;
  logic                  tout_q, tout_d, fstart_q, fstart_d;
  logic                  trig_q, react_q, trig_edge, react_edge;
  logic [LFSR_W-1:0]     lfsr, hold_sel;

  lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

  assign trig_edge   = trigger & ~trig_q;
  assign react_edge  = react & ~react_q;
  assign lights_fill = (lights_q << 1) | LIGHT0;
  assign hold_sel    = lfsr & HOLD_MASK;
  assign hold_load   = HOLD_W'(MIN_HOLD_MS + 32'(hold_sel) * HOLD_STEP_MS);

  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    step_d   = step_q;
    hold_d   = hold_q;
    rt_d     = rt_q;
    rtime_d  = rtime_q;
    tvalid_d = 1'b0;
    tout_d   = tout_q;
    fstart_d = fstart_q;
    best_d   = best_q;
    case (state_q)
      IDLE, DONE, FAULT: begin
        if (trig_edge) begin
          state_d  = SEQ;
          lights_d = LIGHT0;
          step_d   = '0;
          tout_d   = 1'b0;
          fstart_d = 1'b0;
        end
      end
      SEQ: begin
        if (react_edge) begin
          state_d  = FAULT;
          lights_d = '0;
          fstart_d = 1'b1;
        end else if (tick_ms) begin
          if (step_q == STEP_LAST) begin
            step_d   = '0;
            lights_d = lights_fill;
            if (lights_fill[N_LIGHTS-1]) begin
              state_d = HOLD;
              hold_d  = hold_load;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      HOLD: begin
        // A react edge wins over hold expiry; the hold lasts hold_load ticks.
        if (react_edge) begin
          state_d  = FAULT;
          lights_d = '0;
          fstart_d = 1'b1;
        end else if (tick_ms) begin
          if (hold_q <= HOLD_W'(1)) begin
            state_d  = TIMING;
            lights_d = '0;
            rt_d     = '0;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      TIMING: begin
        if (react_edge) begin
          state_d  = DONE;
          rtime_d  = rt_q;
          tvalid_d = 1'b1;
          if (rt_q < best_q) best_d = rt_q;
        end else if (tick_ms) begin
          rt_d = rt_q + TIME_W'(1);
          if (rt_q == RT_MAX - TIME_W'(1)) begin
            state_d  = DONE;
            tout_d   = 1'b1;
            rtime_d  = RT_MAX;
            tvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEQ) || (state_d == HOLD) || (state_d == TIMING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lights_q <= '0;
      busy_q   <= 1'b0;
      rtime_q  <= '0;
      tvalid_q <= 1'b0;
      tout_q   <= 1'b0;
      fstart_q <= 1'b0;
      best_q   <= '1;
      trig_q   <= 1'b1;
      react_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      busy_q   <= busy_d;
      rtime_q  <= rtime_d;
      tvalid_q <= tvalid_d;
      tout_q   <= tout_d;
      fstart_q <= fstart_d;
      best_q   <= best_d;
      trig_q   <= trigger;
      react_q  <= react;
    end
    step_q <= step_d;
    hold_q <= hold_d;
    rt_q   <= rt_d;
  end

  assign lights      = lights_q;
  assign busy        = busy_q;
  assign react_time  = rtime_q;
  assign time_valid  = tvalid_q;
  assign timeout     = tout_q;
  assign false_start = fstart_q;
  assign best_time   = best_q;

endmodule

// File: tb/tb_f1_start_seq.sv
// Directed-plus-random bench for f1_start_seq with a tick-level timeline model.
module tb_f1_start_seq;

  localparam int N     = 5;
  localparam int STEP  = 2;
  localparam int MINH  = 3;
  localparam int HSTEP = 1;
  localparam int HB    = 2;
  localparam int TW    = 6;
  localparam int TMAX  = (1 << TW) - 1;
  localparam logic [6:0] SEED = 7'h01;

  logic          clk = 1'b0;
  logic          rst, tick_ms, trigger, react;
  logic [N-1:0]  lights;
  logic          busy, time_valid, timeout, false_start;
  logic [TW-1:0] react_time, best_time;

  f1_start_seq #(
    .N_LIGHTS(N), .STEP_MS(STEP), .MIN_HOLD_MS(MINH), .HOLD_BITS(HB),
    .HOLD_STEP_MS(HSTEP), .TIME_W(TW), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .trigger(trigger), .react(react),
    .lights(lights), .busy(busy), .react_time(react_time), .time_valid(time_valid),
    .timeout(timeout), .false_start(false_start), .best_time(best_time)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         phase    = 0;
  bit         ticked;
  int         best_m;
  int         last_rt;
  logic [6:0] lfsr_m;
  logic [6:0] snap;

  // Reference sequence of x^7+x^6+1 starting from the seed after reset
  always @(posedge clk) lfsr_m <= rst ? SEED : {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    if (tick_ms) snap = lfsr_m;
    @(posedge clk);
    ticked = tick_ms;
    @(negedge clk);
    tick_ms = (phase == 3);
    phase   = (phase + 1) % 4;
  endtask

  task automatic wait_ticks(input int n);
    int t = 0;
    while (t < n) begin
      step();
      if (ticked) t++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lights"}, 32'(lights), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rtime"}, 32'(react_time), 0);
    check({tag, "_tvalid"}, 32'(time_valid), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_fstart"}, 32'(false_start), 0);
    check({tag, "_best"}, 32'(best_time), TMAX);
  endtask

  task automatic start_run();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("start_lights", 32'(lights), 1);
    check("start_busy", 32'(busy), 1);
    check("start_fstart", 32'(false_start), 0);
    check("start_timeout", 32'(timeout), 0);
  endtask

  task automatic fill_lights();
    for (int k = 2; k <= N; k++) begin
      wait_ticks(STEP - 1);
      check("seq_steady", 32'(lights), (1 << (k - 1)) - 1);
      wait_ticks(1);
      check("seq_fill", 32'(lights), (1 << k) - 1);
    end
  endtask

  function automatic int hold_len();
    return MINH + int'(snap[HB-1:0]) * HSTEP;
  endfunction

  task automatic hold_phase();
    int h = hold_len();
    wait_ticks(h - 1);
    check("hold_on", 32'(lights), (1 << N) - 1);
    wait_ticks(1);
    check("hold_out_lights", 32'(lights), 0);
    check("hold_out_busy", 32'(busy), 1);
  endtask

  task automatic react_run(input int r);
    int j = int'($urandom_range(0, 3));
    wait_ticks(r);
    repeat (j) step();
    react = 1'b1;
    step();
    if (r < best_m) best_m = r;
    last_rt = r;
    check("react_time", 32'(react_time), r);
    check("react_tvalid", 32'(time_valid), 1);
    check("react_busy", 32'(busy), 0);
    check("react_best", 32'(best_time), best_m);
    react = 1'b0;
    step();
    check("react_tvalid_pulse", 32'(time_valid), 0);
    check("react_time_hold", 32'(react_time), r);
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; react = 1'b0; tick_ms = 1'b0;
    best_m = TMAX; last_rt = 0;
    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (int'($urandom_range(1, 8))) step();

    // Normal run and best-time tracking
    start_run(); fill_lights(); hold_phase(); react_run(7);
    repeat (int'($urandom_range(0, 6))) step();
    start_run(); fill_lights(); hold_phase(); react_run(4);
    check("best_after_4", 32'(best_time), 4);
    repeat (int'($urandom_range(0, 6))) step();
    start_run(); fill_lights(); hold_phase(); react_run(9);
    check("best_stays_4", 32'(best_time), 4);

    repeat (3) begin
      repeat (int'($urandom_range(0, 10))) step();
      start_run(); fill_lights(); hold_phase(); react_run(int'($urandom_range(0, 20)));
    end

    // False start while three lights are on
    start_run();
    wait_ticks(2 * STEP);
    check("fs_pre_lights", 32'(lights), 7);
    repeat (int'($urandom_range(0, 3))) step();
    react = 1'b1;
    step();
    check("fs_flag", 32'(false_start), 1);
    check("fs_lights", 32'(lights), 0);
    check("fs_busy", 32'(busy), 0);
    check("fs_tvalid", 32'(time_valid), 0);
    check("fs_rtime", 32'(react_time), last_rt);
    check("fs_best", 32'(best_time), best_m);
    react = 1'b0;
    repeat (3) step();
    check("fs_sticky", 32'(false_start), 1);

    // Restart from FAULT, then let the reaction counter saturate
    start_run(); fill_lights(); hold_phase();
    wait_ticks(TMAX - 1);
    check("to_not_yet", 32'(timeout), 0);
    check("to_busy", 32'(busy), 1);
    wait_ticks(1);
    check("to_flag", 32'(timeout), 1);
    check("to_rtime", 32'(react_time), TMAX);
    check("to_tvalid", 32'(time_valid), 1);
    check("to_best", 32'(best_time), best_m);
    check("to_busy_done", 32'(busy), 0);
    last_rt = TMAX;
    step();
    check("to_tvalid_pulse", 32'(time_valid), 0);

    // React edge on the exact hold-expiry tick
    start_run(); fill_lights();
    begin
      int h = hold_len();
      wait_ticks(h - 1);
    end
    while (!tick_ms) step();
    react = 1'b1;
    step();
    check("bnd_fstart", 32'(false_start), 1);
    check("bnd_lights", 32'(lights), 0);
    check("bnd_busy", 32'(busy), 0);
    check("bnd_rtime", 32'(react_time), last_rt);
    react = 1'b0;
    step();

    // Trigger and react together in FAULT: trigger wins
    trigger = 1'b1; react = 1'b1;
    step();
    trigger = 1'b0; react = 1'b0;
    check("tr_win_lights", 32'(lights), 1);
    check("tr_win_fstart", 32'(false_start), 0);
    check("tr_win_busy", 32'(busy), 1);
    fill_lights(); hold_phase();

    // Trigger during TIMING is ignored
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    check("tim_trig_busy", 32'(busy), 1);
    check("tim_trig_lights", 32'(lights), 0);
    react_run(5);

    // Reset during HOLD with trigger held high through it
    start_run(); fill_lights();
    trigger = 1'b1; rst = 1'b1;
    step();
    best_m = TMAX; last_rt = 0;
    check_reset_vals("midrst");
    rst = 1'b0;
    wait_ticks(3);
    check("held_trig_lights", 32'(lights), 0);
    check("held_trig_busy", 32'(busy), 0);
    trigger = 1'b0;
    step();
    start_run(); fill_lights(); hold_phase(); react_run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
